// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and FSM state encoding for the SPI controller
package spi_pkg;
  localparam int SPI_MODE = 0;
  localparam int BYTE_W = 8;
  localparam int EDGES_PER_BYTE = 16;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, NEXT, TRAIL, GAP} state_t;
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period and edge counters producing sclk rise/fall/done strobes
module spi_sclk_gen import spi_pkg::*; #(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic rise,
  output logic fall,
  output logic done
);
  localparam int CW = $clog2(CLKS_PER_HALF_BIT + 1);
  logic [CW-1:0] cnt;
  logic [4:0] edges;
  logic tick;
  // an sclk edge is due once the half period has elapsed; edges stop at 16
  always_comb begin
    tick = en & (cnt == CW'(CLKS_PER_HALF_BIT - 1)) & (edges != 5'(EDGES_PER_BYTE));
    rise = tick & ~edges[0];
    fall = tick & edges[0];
    done = fall & (edges == 5'(EDGES_PER_BYTE - 1));
  end
  // clear restarts the byte so the first edge lands one half period after it
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      edges <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) edges <= edges + 5'd1;
    end
  end
endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator with valid/ready byte stream and framed CS
module spi_controller import spi_pkg::*; #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] i_tx_byte,
  input  logic              i_tx_valid,
  input  logic              i_tx_last,
  output logic              o_tx_ready,
  output logic [BYTE_W-1:0] o_rx_byte,
  output logic              o_rx_dv,
  output logic              o_busy,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_cs_n
);
  localparam int WW = $clog2(CLKS_PER_HALF_BIT + CS_INACTIVE_CLKS + 1);
  state_t state;
  logic [BYTE_W-1:0] tx_sr, rx_sr;
  logic last;
  logic [WW-1:0] wcnt;
  logic accept, rise, fall, done;
  assign accept = i_tx_valid & o_tx_ready;
  spi_sclk_gen #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) u_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (state == LEAD || state == SHIFT),
    .rise  (rise),
    .fall  (fall),
    .done  (done)
  );
  // transaction FSM: load byte, shift on sclk edges, hold CS through trail, then enforce gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx_sr <= '0;
      rx_sr <= '0;
      last <= 1'b0;
      wcnt <= '0;
      o_tx_ready <= 1'b0;
      o_rx_byte <= '0;
      o_rx_dv <= 1'b0;
      o_busy <= 1'b0;
      o_sclk <= 1'b0;
      o_mosi <= 1'b0;
      o_cs_n <= 1'b1;
    end else begin
      o_rx_dv <= 1'b0;
      case (state)
        IDLE, NEXT: begin
          if (accept) begin
            tx_sr <= i_tx_byte;
            last <= i_tx_last;
            o_mosi <= i_tx_byte[BYTE_W-1];
            o_cs_n <= 1'b0;
            o_tx_ready <= 1'b0;
            o_busy <= 1'b1;
            state <= LEAD;
          end else o_tx_ready <= 1'b1;
        end
        LEAD, SHIFT: begin
          if (rise) begin
            o_sclk <= 1'b1;
            rx_sr <= {rx_sr[BYTE_W-2:0], i_miso};
            state <= SHIFT;
          end
          if (fall) begin
            o_sclk <= 1'b0;
            if (done) begin
              o_rx_byte <= rx_sr;
              o_rx_dv <= 1'b1;
              wcnt <= '0;
              o_tx_ready <= ~last;
              state <= last ? TRAIL : NEXT;
            end else begin
              tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
              o_mosi <= tx_sr[BYTE_W-2];
            end
          end
        end
        TRAIL: begin
          if (wcnt == WW'(CLKS_PER_HALF_BIT)) begin
            o_cs_n <= 1'b1;
            wcnt <= '0;
            state <= GAP;
          end else wcnt <= wcnt + WW'(1);
        end
        GAP: begin
          if (wcnt == WW'(CS_INACTIVE_CLKS - 1)) begin
            o_busy <= 1'b0;
            o_tx_ready <= 1'b1;
            state <= IDLE;
          end else wcnt <= wcnt + WW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed self-checking bench for spi_controller
module tb_spi_controller;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [7:0] tx_byte = 0, rx_byte;
  logic tx_valid = 0, tx_last = 0, tx_ready, rx_dv, busy, sclk, mosi, miso, cs_n;
  logic [7:0] tx_byte1 = 0, rx_byte1;
  logic tx_valid1 = 0, tx_last1 = 0, tx_ready1, rx_dv1, busy1, sclk1, mosi1, cs_n1;
  logic miso1 = 0;
  int checks = 0, failures = 0, cyc = 0, base = 0;

  spi_controller #(.CLKS_PER_HALF_BIT(2), .CS_INACTIVE_CLKS(4)) u_dut (
    .clk(clk), .rst(rst), .i_tx_byte(tx_byte), .i_tx_valid(tx_valid), .i_tx_last(tx_last),
    .o_tx_ready(tx_ready), .o_rx_byte(rx_byte), .o_rx_dv(rx_dv), .o_busy(busy),
    .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso), .o_cs_n(cs_n));

  spi_controller #(.CLKS_PER_HALF_BIT(1), .CS_INACTIVE_CLKS(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_tx_byte(tx_byte1), .i_tx_valid(tx_valid1), .i_tx_last(tx_last1),
    .o_tx_ready(tx_ready1), .o_rx_byte(rx_byte1), .o_rx_dv(rx_dv1), .o_busy(busy1),
    .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(miso1), .o_cs_n(cs_n1));

  always @(posedge clk) cyc <= cyc + 1;

  // mode-0 peripheral: presents bit7 on CS fall, shifts out on sclk fall, samples pico on rise
  logic loop = 1;
  logic [7:0] reply = 0, per_tx = 0, per_rx = 0;
  assign miso = loop ? mosi : per_tx[7];
  always @(negedge cs_n) per_tx <= reply;
  always @(negedge sclk) per_tx <= {per_tx[6:0], 1'b0};
  always @(posedge sclk) per_rx <= {per_rx[6:0], mosi};

  // observer for the H=2 instance, sampled mid-cycle
  logic clr = 0;
  int dv_cnt, rise_cnt, first_rise, last_dv_cyc, mosi_err, cs_rise_cnt, cs_rise_abs, last_cs_rise;
  int last_gap, gap_ready_err, next_sclk_err;
  logic [7:0] last_rx;
  logic [23:0] rx_hist;
  logic p_sclk = 0, p_mosi = 0, p_cs_n = 1;
  always @(negedge clk) begin
    if (clr) begin
      dv_cnt = 0; rise_cnt = 0; first_rise = -1; last_dv_cyc = -1; mosi_err = 0;
      cs_rise_cnt = 0; cs_rise_abs = -1; last_cs_rise = -1; last_gap = -1;
      gap_ready_err = 0; next_sclk_err = 0; last_rx = 0; rx_hist = 0;
    end else begin
      if (rx_dv) begin
        dv_cnt++; last_dv_cyc = cyc - base; last_rx = rx_byte; rx_hist = {rx_hist[15:0], rx_byte};
      end
      if (sclk && !p_sclk) begin
        rise_cnt++;
        if (first_rise < 0) first_rise = cyc - base;
        if (mosi !== p_mosi) mosi_err++;
      end
      if (cs_n && !p_cs_n) begin cs_rise_cnt++; cs_rise_abs = cyc; last_cs_rise = cyc - base; end
      if (!cs_n && p_cs_n && cs_rise_abs >= 0) last_gap = cyc - cs_rise_abs;
      if (cs_n && busy && tx_ready) gap_ready_err++;
      if (!cs_n && tx_ready && sclk) next_sclk_err++;
    end
    p_sclk = sclk; p_mosi = mosi; p_cs_n = cs_n;
  end

  task automatic clear_stats();
    clr = 1;
    @(negedge clk);
    #1 clr = 0;
  endtask

  // present a byte and hold it until accepted; returns #1 into cycle 1
  task automatic send(input logic [7:0] b, input logic l);
    tx_byte = b; tx_last = l; tx_valid = 1;
    for (int i = 0; i < 300 && !tx_ready; i++) @(negedge clk);
    checks++;
    if (!tx_ready) begin failures++; $display("FAIL send_accept got ready=%0b exp=1", tx_ready); end
    @(posedge clk);
    #1 base = cyc - 1;
    tx_valid = 0; tx_last = ~l; tx_byte = ~b;
  endtask

  task automatic wait_dut(input bit idle, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_ready && !(idle && busy)) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sclk, cs_n, mosi, rx_byte, rx_dv, tx_ready, busy} !== {3'b010, 8'h00, 3'b000}) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", {sclk, cs_n, mosi, rx_byte, rx_dv, tx_ready, busy}, {3'b010, 8'h00, 3'b000});
    end
    checks++;
    if ({sclk1, cs_n1, mosi1, rx_byte1, rx_dv1, tx_ready1, busy1} !== {3'b010, 8'h00, 3'b000}) begin
      failures++; $display("FAIL reset_outputs_h1 got=%b exp=%b", {sclk1, cs_n1, mosi1, rx_byte1, rx_dv1, tx_ready1, busy1}, {3'b010, 8'h00, 3'b000});
    end
    rst = 0;
    @(posedge clk);
    #1;
    checks++;
    if ({tx_ready, busy} !== 2'b10) begin failures++; $display("FAIL idle_ready got=%b exp=10", {tx_ready, busy}); end
  endtask

  task automatic test_loopback();
    bit ok;
    loop = 1;
    clear_stats();
    send(8'hA5, 1);
    checks++;
    if ({cs_n, mosi, sclk, busy, tx_ready} !== 5'b01010) begin
      failures++; $display("FAIL cycle1_state got=%b exp=01010", {cs_n, mosi, sclk, busy, tx_ready});
    end
    wait_dut(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL loop_idle_timeout got=%0b exp=1", ok); end
    checks++;
    if (last_dv_cyc !== 33) begin failures++; $display("FAIL loop_dv_cycle got=%0d exp=33", last_dv_cyc); end
    checks++;
    if (last_rx !== 8'hA5) begin failures++; $display("FAIL loop_rx got=%0h exp=a5", last_rx); end
    checks++;
    if (dv_cnt !== 1) begin failures++; $display("FAIL loop_dv_count got=%0d exp=1", dv_cnt); end
    checks++;
    if (last_cs_rise !== 36) begin failures++; $display("FAIL loop_cs_release got=%0d exp=36", last_cs_rise); end
    checks++;
    if (first_rise !== 3 || rise_cnt !== 8) begin
      failures++; $display("FAIL loop_sclk got first=%0d rises=%0d exp first=3 rises=8", first_rise, rise_cnt);
    end
  endtask

  task automatic test_peripheral();
    bit ok;
    loop = 0; reply = 8'h3C;
    clear_stats();
    send(8'hC3, 1);
    wait_dut(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL periph_idle_timeout got=%0b exp=1", ok); end
    checks++;
    if (last_rx !== 8'h3C || dv_cnt !== 1) begin
      failures++; $display("FAIL periph_rx got=%0h dv=%0d exp=3c dv=1", last_rx, dv_cnt);
    end
    checks++;
    if (per_rx !== 8'hC3) begin failures++; $display("FAIL periph_seen got=%0h exp=c3", per_rx); end
    checks++;
    if (mosi_err !== 0) begin failures++; $display("FAIL mosi_stable got=%0d exp=0", mosi_err); end
    loop = 1;
  endtask

  task automatic test_multibyte();
    bit ok;
    loop = 1;
    clear_stats();
    send(8'h01, 0);
    wait_dut(0, ok);
    checks++;
    if (!ok || {cs_n, sclk, busy} !== 3'b001) begin
      failures++; $display("FAIL next_state got ok=%0b cs_sclk_busy=%b exp ok=1 001", ok, {cs_n, sclk, busy});
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({cs_n, tx_ready} !== 2'b01) begin failures++; $display("FAIL next_wait got=%b exp=01", {cs_n, tx_ready}); end
    send(8'h02, 0);
    wait_dut(0, ok);
    send(8'h03, 1);
    wait_dut(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL multi_idle_timeout got=%0b exp=1", ok); end
    checks++;
    if (dv_cnt !== 3 || rx_hist !== 24'h010203) begin
      failures++; $display("FAIL multi_rx got dv=%0d hist=%0h exp dv=3 hist=10203", dv_cnt, rx_hist);
    end
    checks++;
    if (cs_rise_cnt !== 1) begin failures++; $display("FAIL multi_cs_rises got=%0d exp=1", cs_rise_cnt); end
    checks++;
    if (next_sclk_err !== 0) begin failures++; $display("FAIL next_sclk_low got=%0d exp=0", next_sclk_err); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    loop = 1;
    clear_stats();
    send(8'h5A, 1);
    send(8'h96, 1);
    wait_dut(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_idle_timeout got=%0b exp=1", ok); end
    checks++;
    if (dv_cnt !== 2 || rx_hist[15:0] !== 16'h5A96) begin
      failures++; $display("FAIL b2b_rx got dv=%0d hist=%0h exp dv=2 hist=5a96", dv_cnt, rx_hist[15:0]);
    end
    checks++;
    if (last_gap < 4) begin failures++; $display("FAIL b2b_cs_gap got=%0d exp>=4", last_gap); end
    checks++;
    if (gap_ready_err !== 0) begin failures++; $display("FAIL gap_ready_low got=%0d exp=0", gap_ready_err); end
    checks++;
    if (cs_rise_cnt !== 2) begin failures++; $display("FAIL b2b_cs_rises got=%0d exp=2", cs_rise_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    loop = 1;
    clear_stats();
    send(8'h81, 1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rise_cnt >= 3) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_rise_timeout got=%0d exp=3", rise_cnt); end
    rst = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({cs_n, sclk, rx_dv, busy, rx_byte} !== {4'b1000, 8'h00}) begin
      failures++; $display("FAIL mid_abort got=%b exp=%b", {cs_n, sclk, rx_dv, busy, rx_byte}, {4'b1000, 8'h00});
    end
    rst = 0;
    repeat (40) @(negedge clk);
    checks++;
    if (dv_cnt !== 0) begin failures++; $display("FAIL mid_no_dv got=%0d exp=0", dv_cnt); end
    clear_stats();
    send(8'h3C, 1);
    wait_dut(1, ok);
    checks++;
    if (!ok || last_rx !== 8'h3C || dv_cnt !== 1) begin
      failures++; $display("FAIL mid_recover got ok=%0b rx=%0h dv=%0d exp ok=1 rx=3c dv=1", ok, last_rx, dv_cnt);
    end
  endtask

  task automatic test_h1();
    int b1, dv_at = -1, dvs = 0, rises = 0, first = -1, last_r = -1, per_err = 0, cs_up = -1;
    logic ps = 0, pc = 0;
    tx_byte1 = 8'hFF; tx_last1 = 1; tx_valid1 = 1; miso1 = 0;
    for (int i = 0; i < 20 && !tx_ready1; i++) @(negedge clk);
    @(posedge clk);
    #1 b1 = cyc - 1;
    tx_valid1 = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rx_dv1) begin dv_at = cyc - b1; dvs++; end
      if (sclk1 && !ps) begin
        rises++;
        if (first < 0) first = cyc - b1;
        else if (cyc - b1 - last_r != 2) per_err++;
        last_r = cyc - b1;
      end
      if (cs_n1 && !pc) cs_up = cyc - b1;
      ps = sclk1; pc = cs_n1;
    end
    checks++;
    if (rx_byte1 !== 8'h00 || dvs !== 1) begin
      failures++; $display("FAIL h1_rx got=%0h dv=%0d exp=0 dv=1", rx_byte1, dvs);
    end
    checks++;
    if (dv_at !== 17) begin failures++; $display("FAIL h1_dv_cycle got=%0d exp=17", dv_at); end
    checks++;
    if (first !== 2 || rises !== 8 || per_err !== 0) begin
      failures++; $display("FAIL h1_sclk got first=%0d rises=%0d per_err=%0d exp 2 8 0", first, rises, per_err);
    end
    checks++;
    if (cs_up !== 19) begin failures++; $display("FAIL h1_cs_release got=%0d exp=19", cs_up); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_peripheral();
    test_multibyte();
    test_back_to_back();
    test_reset_mid();
    test_h1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
